// File: rtl/axi4_mem_slave_param.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_mem_slave_param
//  Brief    : Parameterised AXI4 memory slave with independent read and write
//             engines, narrow/wrap bursts, legality and range checks (SLVERR).
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_mem_slave_param #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address channel
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    // write response channel
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // read address channel
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    // read data channel
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int c_data_bytes = DATA_WIDTH / 8;
    localparam int c_db_log     = $clog2(c_data_bytes);
    localparam int c_mem_log    = $clog2(MEM_BYTES);
    localparam int c_words      = MEM_BYTES / c_data_bytes;
    localparam int c_idx_w      = (c_words > 1) ? $clog2(c_words) : 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Shared burst helpers
    // ------------------------------------------------------------------
    function automatic logic f_illegal(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(c_db_log)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [ADDR_WIDTH-1:0] start,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] sz;
        logic [ADDR_WIDTH-1:0] wb;
        logic [ADDR_WIDTH-1:0] lower;
        logic [ADDR_WIDTH-1:0] nxt;
        sz    = ADDR_WIDTH'(1) << size;
        wb    = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * sz;
        lower = start & ~(wb - ADDR_WIDTH'(1));
        nxt   = cur + sz;
        case (burst)
            2'b00:   nxt = cur;
            2'b10:   if (nxt == lower + wb) nxt = lower;
            default: nxt = (cur & ~(sz - ADDR_WIDTH'(1))) + sz;
        endcase
        return nxt;
    endfunction

    // The word address is in range exactly when no bit above the memory size is set.
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> c_mem_log) == '0;
    endfunction

    function automatic logic [c_idx_w-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
        return c_idx_w'(addr >> c_db_log);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [c_words];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wstate_t               r_wstate;
    wstate_t               w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_wstart;
    logic [7:0]            r_wlen;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic [7:0]            r_wcnt;
    logic                  r_werr;
    logic                  r_willegal;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic                  w_wfinal;
    logic                  w_win_range;
    logic                  w_wbeat_err;
    logic                  w_wbeat;

    assign w_wfinal    = (r_wcnt == r_wlen);
    assign w_win_range = f_in_range(r_waddr);
    assign w_wbeat_err = !w_win_range || (wlast != w_wfinal);
    assign w_wbeat     = (r_wstate == W_DATA) && wvalid;

    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_wfinal) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr    <= '0;
            r_wstart   <= '0;
            r_wlen     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
            r_willegal <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= 2'b00;
        end else if ((r_wstate == W_IDLE) && awvalid) begin
            r_waddr    <= awaddr;
            r_wstart   <= awaddr;
            r_wlen     <= awlen;
            r_wsize    <= awsize;
            r_wburst   <= awburst;
            r_wcnt     <= '0;
            r_werr     <= f_illegal(awsize, awburst, awlen);
            r_willegal <= f_illegal(awsize, awburst, awlen);
            r_bid      <= awid;
        end else if (w_wbeat) begin
            r_wcnt  <= r_wcnt + 8'd1;
            r_waddr <= f_next_addr(r_waddr, r_wstart, r_wlen, r_wsize, r_wburst);
            if (w_wbeat_err) r_werr <= 1'b1;
            if (w_wfinal)    r_bresp <= (r_werr || w_wbeat_err) ? 2'b10 : 2'b00;
        end
    end

    // Memory contents survive reset; only the beat in flight during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wbeat && !r_willegal && w_win_range) begin
            for (int i = 0; i < c_data_bytes; i++) begin
                if (wstrb[i]) r_mem[f_idx(r_waddr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign bid   = r_bid;
    assign bresp = r_bresp;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rstate_t               r_rstate;
    rstate_t               w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH-1:0] r_rstart;
    logic [7:0]            r_rlen;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic [7:0]            r_rcnt;
    logic                  r_rillegal;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  w_ar_illegal;
    logic [ADDR_WIDTH-1:0] w_rload_addr;
    logic                  w_rload_bad;
    logic                  w_rload_last;
    logic                  w_ar_accept;
    logic                  w_r_advance;

    assign w_ar_illegal = f_illegal(arsize, arburst, arlen);
    assign w_ar_accept  = (r_rstate == R_IDLE) && arvalid;
    assign w_r_advance  = (r_rstate == R_DATA) && rready && !r_rlast;

    // One address/lookup path serves both the first beat and every follow-on beat.
    always_comb begin
        w_rload_addr = araddr;
        w_rload_bad  = w_ar_illegal;
        w_rload_last = (arlen == 8'd0);
        if (r_rstate == R_DATA) begin
            w_rload_addr = f_next_addr(r_raddr, r_rstart, r_rlen, r_rsize, r_rburst);
            w_rload_bad  = r_rillegal;
            w_rload_last = ((r_rcnt + 8'd1) == r_rlen);
        end
        w_rload_bad = w_rload_bad || !f_in_range(w_rload_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr    <= '0;
            r_rstart   <= '0;
            r_rlen     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rcnt     <= '0;
            r_rillegal <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_rlast    <= 1'b0;
        end else if (w_ar_accept || w_r_advance) begin
            if (w_ar_accept) begin
                r_rstart   <= araddr;
                r_rlen     <= arlen;
                r_rsize    <= arsize;
                r_rburst   <= arburst;
                r_rcnt     <= '0;
                r_rillegal <= w_ar_illegal;
                r_rid      <= arid;
            end else begin
                r_rcnt     <= r_rcnt + 8'd1;
            end
            r_raddr <= w_rload_addr;
            r_rdata <= w_rload_bad ? '0 : r_mem[f_idx(w_rload_addr)];
            r_rresp <= w_rload_bad ? 2'b10 : 2'b00;
            r_rlast <= w_rload_last;
        end else if ((r_rstate == R_DATA) && rready) begin
            r_rlast <= 1'b0;
        end
    end

    assign rid   = r_rid;
    assign rdata = r_rdata;
    assign rresp = r_rresp;
    assign rlast = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_slave_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_mem_slave_param
//  Brief    : Randomised self-checking bench against a byte-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_mem_slave_param;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 1024;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    always #5 clk = ~clk;

    axi4_mem_slave_param #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_BYTES  (MB),
        .ID_WIDTH   (IW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem_m [MB];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal_m(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        if (size > 3'd2) return 1'b0;
        if (burst == 2'b11) return 1'b0;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    // Address of beat k computed directly from the start address.
    function automatic logic [31:0] beat_addr_m(input logic [31:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst, input int k);
        logic [31:0] sz;
        logic [31:0] wb;
        logic [31:0] lower;
        sz = 32'd1 << size;
        case (burst)
            2'b01: return (k == 0) ? a : (a & ~(sz - 1)) + 32'(k) * sz;
            2'b10: begin
                wb    = (32'(len) + 1) * sz;
                lower = a & ~(wb - 1);
                return lower + ((a - lower + 32'(k) * sz) % wb);
            end
            default: return a;
        endcase
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bad_last, input int b_hold, input int abort_beat);
        int          t;
        logic        err;
        logic        legal;
        logic [31:0] word;
        legal = legal_m(size, burst, len);
        err   = !legal;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 1000) begin tick(); t++; end
        if (t >= 1000) begin check_eq("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = wd[k]; wstrb = ws[k]; wlast = (k == int'(len)) ^ (k == bad_last); wvalid = 1'b1;
            if (k == abort_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0; wvalid = 1'b0; wlast = 1'b0;
                check_eq("rst_awready", awready, 1);
                check_eq("rst_bvalid", bvalid, 0);
                check_eq("rst_wready", wready, 0);
                return;
            end
            t = 0;
            while (!wready && t < 1000) begin tick(); t++; end
            if (t >= 1000) begin check_eq("w_timeout", 0, 1); wvalid = 1'b0; return; end
            tick();
            word = beat_addr_m(addr, len, size, burst, k) & ~32'd3;
            if (word >= MB) err = 1'b1;
            if (k == bad_last) err = 1'b1;
            if (legal && word < MB)
                for (int i = 0; i < 4; i++)
                    if (ws[k][i]) mem_m[word + i] = wd[k][8*i +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 1000) begin tick(); t++; end
        if (t >= 1000) begin check_eq("b_timeout", 0, 1); return; end
        for (int h = 0; h < b_hold; h++) begin
            check_eq("b_hold_bvalid", bvalid, 1);
            check_eq("b_hold_awready", awready, 0);
            tick();
        end
        check_eq("bid", bid, id);
        check_eq("bresp", bresp, err ? 2'b10 : 2'b00);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("b_once", bvalid, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n);
        int          t;
        logic        bad;
        logic [31:0] word;
        logic [31:0] ed;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 1000) begin tick(); t++; end
        if (t >= 1000) begin check_eq("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        for (int k = 0; k <= int'(len); k++) begin
            word = beat_addr_m(addr, len, size, burst, k) & ~32'd3;
            bad  = !legal_m(size, burst, len) || (word >= MB);
            ed   = '0;
            if (!bad) ed = {mem_m[word + 3], mem_m[word + 2], mem_m[word + 1], mem_m[word]};
            check_eq($sformatf("rvalid_nobubble[%0d]", k), rvalid, 1);
            t = 0;
            while (!rvalid && t < 1000) begin tick(); t++; end
            if (t >= 1000) begin check_eq("r_timeout", 0, 1); rready = 1'b0; return; end
            if (k == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check_eq("stall_rvalid", rvalid, 1);
                    check_eq("stall_rdata", rdata, ed);
                    check_eq("stall_rresp", rresp, bad ? 2'b10 : 2'b00);
                    check_eq("stall_rlast", rlast, k == int'(len));
                end
                rready = 1'b1;
            end
            check_eq($sformatf("rid[%0d]", k), rid, id);
            check_eq($sformatf("rdata[%0d]", k), rdata, ed);
            check_eq($sformatf("rresp[%0d]", k), rresp, bad ? 2'b10 : 2'b00);
            check_eq($sformatf("rlast[%0d]", k), rlast, k == int'(len));
            tick();
        end
        rready = 1'b0;
        check_eq("r_end_rvalid", rvalid, 0);
        check_eq("r_end_arready", arready, 1);
    endtask

    initial begin
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr;
        int          r;
        int          bad_last;

        repeat (3) tick();
        rst = 1'b0;
        check_eq("reset_awready", awready, 1);
        check_eq("reset_arready", arready, 1);
        check_eq("reset_wready", wready, 0);
        check_eq("reset_bvalid", bvalid, 0);
        check_eq("reset_rvalid", rvalid, 0);
        check_eq("reset_rlast", rlast, 0);
        check_eq("reset_bresp", bresp, 0);
        check_eq("reset_rresp", rresp, 0);
        check_eq("reset_bid", bid, 0);
        check_eq("reset_rid", rid, 0);
        check_eq("reset_rdata", rdata, 0);

        // Fill the whole memory so the model starts from known contents.
        for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'h1, 32'h0, 8'd255, 3'd2, 2'b01, -1, 0, -1);

        // Aligned INCR write and read-back.
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int k = 0; k < 4; k++) ws[k] = 4'hF;
        do_write(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, -1, 0, -1);
        do_read(4'h9, 32'h10, 8'd3, 3'd2, 2'b01, -1, 0);

        do_read(4'h3, 32'h18, 8'd3, 3'd2, 2'b10, -1, 0);

        // FIXED burst merging two half-word strobes.
        wd[0] = 32'hAAAAAAAA; ws[0] = 4'b0011;
        wd[1] = 32'hBBBBBBBB; ws[1] = 4'b1100;
        do_write(4'h2, 32'h20, 8'd1, 3'd2, 2'b00, -1, 0, -1);
        do_read(4'h2, 32'h20, 8'd0, 3'd2, 2'b01, -1, 0);

        // Oversized beat: SLVERR and no memory change.
        wd[0] = 32'hDEADBEEF; wd[1] = 32'hCAFEF00D; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'h6, 32'h40, 8'd1, 3'd3, 2'b01, -1, 0, -1);
        do_read(4'h6, 32'h40, 8'd1, 3'd2, 2'b01, -1, 0);

        do_read(4'h7, 32'(MB - 4), 8'd1, 3'd2, 2'b01, -1, 0);

        // Early wlast.
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'h8, 32'h80, 8'd3, 3'd2, 2'b01, 1, 0, -1);
        do_read(4'h8, 32'h80, 8'd3, 3'd2, 2'b01, -1, 0);

        // Backpressure on B and R.
        for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'hA, 32'hA0, 8'd2, 3'd2, 2'b01, -1, 4, -1);
        do_read(4'hB, 32'hA0, 8'd7, 3'd2, 2'b01, 2, 5);

        // Reset during beat 2 of an 8-beat write.
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'hC, 32'h100, 8'd7, 3'd2, 2'b01, -1, 0, 2);
        do_read(4'hD, 32'h100, 8'd1, 3'd2, 2'b01, -1, 0);

        for (int it = 0; it < 40; it++) begin
            r     = $urandom_range(0, 9);
            burst = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
            size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == 2'b10) begin
                r   = $urandom_range(0, 4);
                len = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : (r == 3) ? 8'd15 : 8'd2;
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            addr = 32'($urandom_range(0, MB + 63));
            if (burst == 2'b10) addr = addr & ~((32'd1 << size) - 1);
            for (int k = 0; k <= int'(len); k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
            bad_last = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
            do_write(4'($urandom), addr, len, size, burst, bad_last, $urandom_range(0, 2), -1);
            do_read(4'($urandom), addr, len, size, burst,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : -1, $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/axi4_mem_slave_param.md
Name: axi4_mem_slave_param

Overview:
Parameterised AXI4 memory slave; the next generation of the team's 32-bit/8-bit-mem AXI slave. Adds configurable data bus width, memory depth and ID width, plus 8-bit AWLEN/ARLEN and narrow transfers. Checks legality and address range, and returns SLVERR. Independent read and write engines sit behind the interconnect as the verification-target memory.

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 32, data bus width in bits; legal values 32 or 64; DATA_BYTES = DATA_WIDTH/8.
MEM_BYTES, 1024, memory size in bytes; power of two, at least DATA_BYTES.
ID_WIDTH, 4, AXI ID width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
awid  in  ID_WIDTH  write ID.
awaddr  in  ADDR_WIDTH  write start address.
awlen  in  8  beats minus 1.
awsize  in  3  log2 of bytes per beat.
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
awvalid/awready  in/out  1 each  AW handshake.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_BYTES  byte strobes.
wlast  in  1  last write beat.
wvalid/wready  in/out  1 each  W handshake.
bid  out  ID_WIDTH  response ID (latched awid).
bresp  out  2  00 OKAY, 10 SLVERR.
bvalid/bready  out/in  1 each  B handshake.
arid, araddr, arlen, arsize, arburst  in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2  read address fields, same encodings as AW.
arvalid/arready  in/out  1 each  AR handshake.
rid  out  ID_WIDTH  latched arid.
rdata  out  DATA_WIDTH  read data.
rresp  out  2  per-beat response.
rlast  out  1  last read beat.
rvalid/rready  out/in  1 each  R handshake.

Behaviour:
- Reset (rst=1 at clk edge): both engines go to IDLE; awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp=rresp=00; bid=rid=0; rdata=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid, latch id, addr, len, size and burst; clear beat count and error flag; go to W_DATA.
  - W_DATA: wready=1. Each beat with wvalid: for each lane i with wstrb[i], write mem[(beat_addr & ~(DATA_BYTES-1)) + i] = wdata[8i+:8], provided the word is in range. Then increment count and advance beat_addr. After the beat where count==awlen, go to W_RESP.
  - W_RESP: bvalid=1; bid and bresp stay stable until bready, then return to W_IDLE. Exactly one B per AW.
- Write error flag (sets bresp=10):
  - awsize > log2(DATA_BYTES);
  - awburst==11;
  - WRAP with awlen not in {1,3,7,15};
  - any beat with word address >= MEM_BYTES;
  - wlast != (count==awlen) on any beat.
  - Illegal bursts still consume awlen+1 beats and write nothing. Out-of-range beats are dropped; in-range beats of the same burst are still written.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, latch fields and load the first beat into output registers; rvalid=1 the next cycle (1-cycle latency).
  - R_DATA: rdata holds the word at beat_addr & ~(DATA_BYTES-1); rlast=(count==arlen); rresp=10 if the burst is illegal (same rules as write) or this beat is out of range, in which case rdata=0.
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - On rready, the next beat is registered with no bubble (back-to-back beats).
  - On rready with rlast, rvalid=0 and return to R_IDLE; arready goes back to 1 the following cycle.
- Address arithmetic (SZ = 1<<size, done at ADDR_WIDTH, modulo 2^ADDR_WIDTH):
  - FIXED: beat_addr is unchanged.
  - INCR: next = (beat_addr & ~(SZ-1)) + SZ.
  - WRAP: wb = (len+1)*SZ; lower = addr & ~(wb-1); next = beat_addr+SZ, and next = lower when it reaches lower+wb.
- Read and write engines run concurrently. A same-cycle write and read of one word returns the pre-write data. The read engine never waits on the write engine.

Test Plan:
- INCR write: awaddr=0x10, awlen=3, awsize=2, data 0x11111111..0x44444444, wstrb=F -> one B with bresp=00, bid=awid; INCR read of the same burst returns the 4 words in order, rlast on beat 3 only.
- WRAP read: araddr=0x18, arlen=3, arsize=2, memory preloaded -> addresses 0x18, 0x1C, 0x10, 0x14; rresp=00.
- Strobes and FIXED: FIXED write to 0x20, awlen=1, beat0 wstrb=0011 data 0xAAAAAAAA, beat1 wstrb=1100 data 0xBBBBBBBB -> word at 0x20 reads 0xBBBBAAAA.
- Errors:
  - awsize=3 with DATA_WIDTH=32 -> bresp=10, memory unchanged.
  - araddr=MEM_BYTES-4, arlen=1 -> beat0 rresp=00, beat1 rresp=10 with rdata=0.
  - wlast asserted on beat 1 of awlen=3 -> bresp=10 after 4 beats.
- Backpressure: hold rready=0 for 5 cycles mid-burst -> rdata, rresp and rlast stay stable; hold bready=0 -> bvalid stays 1 and no new AW is accepted.
- Reset mid-operation: assert rst during beat 2 of an 8-beat write -> next cycle awready=1, bvalid=0, wready=0; a following read of beats 0-1 returns the data already written.
